// File: rtl/gate_scanner_if.sv
// Pin and result bundle between the gate scanner and the board-level glue.
// slave is the scanner's view; master is the top-level/bench view.
interface gate_scanner_if #(
    parameter int PINS = 12
);
    logic                start;
    logic [PINS-1:0]     pin_in;
    logic [PINS-1:0]     pin_out;
    logic [PINS-1:0]     pin_dir;
    logic                busy;
    logic                done;
    logic [2:0]          gate_type;
    logic [PINS/2-1:0]   slot_mask;
    logic [2:0]          cand;

    modport master (
        output start, pin_in,
        input  pin_out, pin_dir, busy, done, gate_type, slot_mask, cand
    );

    modport slave (
        input  start, pin_in,
        output pin_out, pin_dir, busy, done, gate_type, slot_mask, cand
    );
endinterface

// File: rtl/gate_scanner.sv
// Sequential logic-IC identifier: walks NOT, AND, OR, XOR slot layouts over the test pins.
// Defining GATE_SCANNER_INVERTED_EN also tries NAND, NOR, XNOR after XOR.
module gate_scanner #(
    parameter int PINS          = 12,
    parameter int SETTLE_CYCLES = 4,
    parameter int MIN_MATCH_1IN = 3,
    parameter int MIN_MATCH_2IN = 2
) (
    input logic           clk,
    input logic           reset,
    gate_scanner_if.slave bus
);
    localparam int SLOTS1 = PINS / 2;
    localparam int SLOTS2 = PINS / 3;
    localparam int SW     = $clog2(SLOTS1);
    localparam logic [SW-1:0] LAST_SLOT1  = SW'(SLOTS1 - 1);
    localparam logic [SW-1:0] LAST_SLOT2  = SW'(SLOTS2 - 1);
    localparam logic [7:0]    SETTLE_LAST = 8'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
`ifdef GATE_SCANNER_INVERTED_EN
    localparam logic [2:0] LAST_CAND = 3'd7;
`else
    localparam logic [2:0] LAST_CAND = 3'd4;
`endif

    typedef enum logic [2:0] {IDLE, RELEASE, DRIVE, SETTLE, SAMPLE, EVAL, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cand_q, cand_d;
    logic [SW-1:0]     slot_q, slot_d;
    logic [1:0]        vec_q, vec_d;
    logic [7:0]        settleCnt_q, settleCnt_d;
    logic              fail_q, fail_d;
    logic [SLOTS1-1:0] passMask_q, passMask_d;
    logic [2:0]        gateType_q, gateType_d;
    logic [SLOTS1-1:0] resultMask_q, resultMask_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PINS-1:0]   pinOut_q, pinOut_d;
    logic [PINS-1:0]   pinDir_q, pinDir_d;

    function automatic logic expectedOut(input logic [2:0] c, input logic a, input logic b);
        case (c)
            3'd1:    expectedOut = ~a;
            3'd2:    expectedOut = a & b;
            3'd3:    expectedOut = a | b;
            3'd4:    expectedOut = a ^ b;
            3'd5:    expectedOut = ~(a & b);
            3'd6:    expectedOut = ~(a | b);
            3'd7:    expectedOut = ~(a ^ b);
            default: expectedOut = 1'b0;
        endcase
    endfunction

    logic            isNot, isNotD, observed, mismatch, slotPass;
    logic [SW-1:0]   lastSlot;
    logic [1:0]      lastVec;
    logic [PINS-1:0] shifted;
    int              outIdx, aIdx, passCount, threshold;

    // Next-state logic; pin drive is derived from the next state so the pins are registered.
    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        slot_d       = slot_q;
        vec_d        = vec_q;
        settleCnt_d  = settleCnt_q;
        fail_d       = fail_q;
        passMask_d   = passMask_q;
        gateType_d   = gateType_q;
        resultMask_d = resultMask_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        pinOut_d     = '0;
        pinDir_d     = '0;

        isNot     = (cand_q == 3'd1);
        lastSlot  = isNot ? LAST_SLOT1 : LAST_SLOT2;
        lastVec   = isNot ? 2'd1 : 2'd3;
        outIdx    = isNot ? 2 * int'(slot_q) + 1 : 3 * int'(slot_q) + 2;
        shifted   = bus.pin_in >> outIdx;
        observed  = shifted[0];
        mismatch  = (observed != expectedOut(cand_q, vec_q[0], vec_q[1]));
        slotPass  = !(fail_q || mismatch);
        threshold = isNot ? MIN_MATCH_1IN : MIN_MATCH_2IN;
        passCount = 0;
        for (int i = 0; i < SLOTS1; i++) begin
            if (passMask_q[i]) passCount++;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    gateType_d   = 3'd0;
                    resultMask_d = '0;
                    cand_d       = 3'd1;
                    busy_d       = 1'b1;
                    state_d      = RELEASE;
                end
            end
            RELEASE: begin
                slot_d     = '0;
                vec_d      = 2'd0;
                fail_d     = 1'b0;
                passMask_d = '0;
                state_d    = DRIVE;
            end
            DRIVE: begin
                settleCnt_d = 8'd0;
                state_d     = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
            end
            SETTLE: begin
                if (settleCnt_q == SETTLE_LAST) state_d = SAMPLE;
                else settleCnt_d = settleCnt_q + 8'd1;
            end
            SAMPLE: begin
                if (vec_q != lastVec) begin
                    vec_d   = vec_q + 2'd1;
                    fail_d  = fail_q | mismatch;
                    state_d = DRIVE;
                end else begin
                    if (slotPass) passMask_d = passMask_q | (SLOTS1'(1) << slot_q);
                    fail_d = 1'b0;
                    vec_d  = 2'd0;
                    if (slot_q == lastSlot) begin
                        state_d = EVAL;
                    end else begin
                        slot_d  = slot_q + SW'(1);
                        state_d = DRIVE;
                    end
                end
            end
            EVAL: begin
                if (passCount >= threshold) begin
                    gateType_d   = cand_q;
                    resultMask_d = passMask_q;
                    state_d      = DONE;
                end else if (cand_q == LAST_CAND) begin
                    gateType_d   = 3'd0;
                    resultMask_d = '0;
                    state_d      = DONE;
                end else begin
                    cand_d  = cand_q + 3'd1;
                    state_d = RELEASE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                cand_d  = 3'd0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        isNotD = (cand_d == 3'd1);
        aIdx   = isNotD ? 2 * int'(slot_d) : 3 * int'(slot_d);
        if (state_d == DRIVE || state_d == SETTLE || state_d == SAMPLE) begin
            if (isNotD) begin
                pinDir_d = PINS'(1) << aIdx;
                pinOut_d = PINS'(vec_d[0]) << aIdx;
            end else begin
                pinDir_d = PINS'(3) << aIdx;
                pinOut_d = PINS'(vec_d) << aIdx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cand_q       <= 3'd0;
            slot_q       <= '0;
            vec_q        <= 2'd0;
            settleCnt_q  <= 8'd0;
            fail_q       <= 1'b0;
            passMask_q   <= '0;
            gateType_q   <= 3'd0;
            resultMask_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pinOut_q     <= '0;
            pinDir_q     <= '0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            slot_q       <= slot_d;
            vec_q        <= vec_d;
            settleCnt_q  <= settleCnt_d;
            fail_q       <= fail_d;
            passMask_q   <= passMask_d;
            gateType_q   <= gateType_d;
            resultMask_q <= resultMask_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pinOut_q     <= pinOut_d;
            pinDir_q     <= pinDir_d;
        end
    end

    assign bus.pin_out   = pinOut_q;
    assign bus.pin_dir   = pinDir_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.gate_type = gateType_q;
    assign bus.slot_mask = resultMask_q;
    assign bus.cand      = cand_q;
endmodule

// File: tb/tb_gate_scanner.sv
// Directed bench for gate_scanner: a behavioural chip socket model answers the pin drive,
// and each scan result is compared against hand-derived family codes and slot masks.
module tb_gate_scanner;
    localparam int PINS = 12;
    localparam logic [PINS-1:0] NOT_OUTS = 12'b1010_1010_1010;
    localparam logic [PINS-1:0] TWO_OUTS = 12'b1001_0010_0100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gate_scanner_if #(.PINS(PINS)) bus();

    gate_scanner #(
        .PINS(PINS), .SETTLE_CYCLES(4), .MIN_MATCH_1IN(3), .MIN_MATCH_2IN(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    int chipKind = 0;

    // Socket model: 0 empty, 1 NOT chip, 2 AND chip with slot 2 stuck low, 3 XOR chip.
    logic [PINS-1:0] drv, chipOut;
    always_comb begin
        drv     = bus.pin_out & bus.pin_dir;
        chipOut = '0;
        case (chipKind)
            1: for (int k = 0; k < PINS / 2; k++) chipOut[2*k+1] = ~drv[2*k];
            2: for (int k = 0; k < PINS / 3; k++) chipOut[3*k+2] = (k == 2) ? 1'b0 : (drv[3*k] & drv[3*k+1]);
            3: for (int k = 0; k < PINS / 3; k++) chipOut[3*k+2] = drv[3*k] ^ drv[3*k+1];
            default: chipOut = '0;
        endcase
        bus.pin_in = drv | (~bus.pin_dir & chipOut);
    end

    // Per-scan observation: done pulses, candidate sequence, drivers on chip outputs.
    int         doneCount = 0;
    int         maxCand   = 0;
    bit         badDrive  = 1'b0;
    logic [2:0] candSeq[$];
    logic [2:0] lastCand  = 3'd0;
    always @(negedge clk) begin
        if (bus.start && !bus.busy && !reset) begin
            maxCand  = 0;
            badDrive = 1'b0;
            candSeq.delete();
        end
        if (bus.done) doneCount++;
        if (int'(bus.cand) > maxCand) maxCand = int'(bus.cand);
        if (bus.cand != lastCand && bus.cand != 3'd0) candSeq.push_back(bus.cand);
        lastCand = bus.cand;
        if (bus.cand == 3'd1 && (bus.pin_dir & NOT_OUTS) != '0) badDrive = 1'b1;
        if (bus.cand >= 3'd2 && (bus.pin_dir & TWO_OUTS) != '0) badDrive = 1'b1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulses start, optionally re-pulses it mid-scan, and counts edges until done is seen.
    task automatic applyStimulus(input int kind, input int extraStarts, output int cycles);
        int extra;
        extra     = extraStarts;
        chipKind  = kind;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cycles    = 1;
        while (!bus.done && cycles < 2000) begin
            if (extra > 0 && (cycles % 10) == 5) begin
                bus.start = 1'b1;
                extra--;
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cycles++;
        end
        bus.start = 1'b0;
        checkOutput("scan_timeout", 32'(cycles < 2000), 32'd1);
    endtask

    int cyc;
    int base;
    int w;

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        chipKind  = 0;
        repeat (3) tick();
        checkOutput("rst_pin_out",   32'(bus.pin_out),   32'd0);
        checkOutput("rst_pin_dir",   32'(bus.pin_dir),   32'd0);
        checkOutput("rst_busy",      32'(bus.busy),      32'd0);
        checkOutput("rst_done",      32'(bus.done),      32'd0);
        checkOutput("rst_gate_type", 32'(bus.gate_type), 32'd0);
        checkOutput("rst_slot_mask", 32'(bus.slot_mask), 32'd0);
        checkOutput("rst_cand",      32'(bus.cand),      32'd0);
        reset = 1'b0;
        tick();

        $display("[TB] NOT chip");
        base = doneCount;
        applyStimulus(1, 0, cyc);
        checkOutput("not_latency",   32'(cyc),            32'd76);
        checkOutput("not_gate_type", 32'(bus.gate_type),  32'd1);
        checkOutput("not_slot_mask", 32'(bus.slot_mask),  32'h3f);
        checkOutput("not_busy",      32'(bus.busy),       32'd0);
        checkOutput("not_cand_idle", 32'(bus.cand),       32'd0);
        checkOutput("not_bad_drive", 32'(badDrive),       32'd0);
        tick();
        checkOutput("not_done_pulse", 32'(bus.done),       32'd0);
        checkOutput("not_done_count", 32'(doneCount - base), 32'd1);
        checkOutput("not_hold_gate",  32'(bus.gate_type),  32'd1);

        $display("[TB] AND chip, slot 2 broken");
        applyStimulus(2, 0, cyc);
        checkOutput("and_gate_type", 32'(bus.gate_type), 32'd2);
        checkOutput("and_slot_mask", 32'(bus.slot_mask), 32'h0b);
        checkOutput("and_bad_drive", 32'(badDrive),      32'd0);
        tick();

        $display("[TB] XOR chip");
        applyStimulus(3, 0, cyc);
        checkOutput("xor_gate_type", 32'(bus.gate_type), 32'd4);
        checkOutput("xor_slot_mask", 32'(bus.slot_mask), 32'h0f);
        checkOutput("xor_seq_len",   32'(candSeq.size()), 32'd4);
        for (int i = 0; i < 4 && i < candSeq.size(); i++)
            checkOutput($sformatf("xor_seq_%0d", i), 32'(candSeq[i]), 32'(i + 1));
        tick();

        $display("[TB] empty socket");
        applyStimulus(0, 0, cyc);
        checkOutput("none_gate_type", 32'(bus.gate_type), 32'd0);
        checkOutput("none_slot_mask", 32'(bus.slot_mask), 32'd0);
`ifdef GATE_SCANNER_INVERTED_EN
        checkOutput("none_max_cand", 32'(maxCand), 32'd7);
`else
        checkOutput("none_max_cand", 32'(maxCand), 32'd4);
`endif
        tick();

        $display("[TB] reset during AND settle");
        chipKind  = 3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        w = 0;
        while (!(bus.cand == 3'd2 && bus.pin_dir != '0) && w < 500) begin
            tick();
            w++;
        end
        checkOutput("and_reach_timeout", 32'(w < 500), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("midrst_pin_dir", 32'(bus.pin_dir),   32'd0);
        checkOutput("midrst_busy",    32'(bus.busy),      32'd0);
        checkOutput("midrst_gate",    32'(bus.gate_type), 32'd0);
        checkOutput("midrst_cand",    32'(bus.cand),      32'd0);
        tick();
        applyStimulus(3, 0, cyc);
        checkOutput("rescan_first_cand", 32'((candSeq.size() > 0) ? candSeq[0] : 3'd0), 32'd1);
        checkOutput("rescan_gate_type",  32'(bus.gate_type), 32'd4);
        tick();

        $display("[TB] start while busy");
        base = doneCount;
        applyStimulus(2, 5, cyc);
        repeat (10) tick();
        checkOutput("busy_done_count", 32'(doneCount - base), 32'd1);
        checkOutput("busy_gate_type",  32'(bus.gate_type),   32'd2);
        checkOutput("busy_slot_mask",  32'(bus.slot_mask),   32'h0b);
        checkOutput("busy_idle",       32'(bus.busy),        32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
